crg_clk_seq: RTL and testbench
==============================

Name: crg_clk_seq

Overview:
- Control sequencer that sits directly upstream of the clock/reset generator.
- Produces that block's per-clock gate enables and its clk1 source select, on the always-on source clock.
- Holds all gated clocks off until MMCM lock is stable, then enables them in a fixed staggered order.
- Performs glitch-safe source switching for the muxed clock: gate off, switch, settle, gate on.

Parameters:
- N_CLK, 4: number of gated clocks / width of clk_req and clk_en.
- SEL_IDX, 1: index of the clk_en bit that gates the muxed clock.
- SEL_INIT, 0: clk1_sel value at reset.
- LOCK_WAIT, 64: consecutive synchronized-lock cycles required before ramp-up.
- EN_GAP, 8: cycles between successive enable slots during ramp-up.
- SW_GATE_WAIT, 16: cycles the muxed clock is gated off before the select changes.
- SW_SETTLE, 16: cycles after the select change before the muxed clock is re-enabled.
- CNT_W, 16: width of the internal wait counter; must hold max(LOCK_WAIT, N_CLK*EN_GAP, SW_GATE_WAIT, SW_SETTLE).

Ports:
- clk_src, in, 1: always-on source clock; all logic is on this clock.
- rst_n_sys, in, 1: asynchronous, active-low reset.
- mmcm_locked, in, 1: MMCM lock; asynchronous; 2-FF synchronized internally to lock_s.
- clk_req, in, N_CLK: requested clock enables; synchronous to clk_src.
- sel_req, in, 1: requested muxed-clock source (0 = source 0, 1 = source 1); synchronous.
- lock_lost_clr, in, 1: clears lock_lost.
- clk_en, out, N_CLK: gate enables to the clock generator.
- clk1_sel, out, 1: mux select to the clock generator.
- ready, out, 1: ramp-up complete and lock held.
- sw_busy, out, 1: source switch in progress.
- lock_lost, out, 1: sticky flag; lock dropped after ramp-up began.

Behaviour:
- All outputs are registered.
- Reset values: clk_en=0, clk1_sel=SEL_INIT, ready=0, sw_busy=0, lock_lost=0, sync flops=0, state=WAIT_LOCK, counter=0.
- WAIT_LOCK: clk_en=0, ready=0. lock_s=1 -> FILTER with counter=0.
- FILTER: counter increments each cycle.
  - lock_s=0 -> WAIT_LOCK; lock_lost is not set.
  - After LOCK_WAIT consecutive cycles -> RAMP. clk1_sel<=sel_req on this transition edge.
- RAMP: lasts exactly N_CLK*EN_GAP cycles.
  - At RAMP cycle i*EN_GAP, clk_en[i]<=clk_req[i], in ascending i.
  - A slot whose request is 0 still consumes its time.
  - Already-issued bits track clk_req with 1-cycle latency.
  - After the last cycle -> RUN, with ready<=1 on that same edge.
- RUN: clk_en<=clk_req every cycle (1-cycle latency).
  - sel_req!=clk1_sel -> SW_GATE. clk_en[SEL_IDX]<=0 and sw_busy<=1 on that edge.
- SW_GATE: clk_en[SEL_IDX] held 0 for SW_GATE_WAIT cycles. On the exit edge, clk1_sel<=sel_req -> SW_SETTLE.
- SW_SETTLE: clk_en[SEL_IDX] held 0 for SW_SETTLE cycles. On the exit edge, clk_en[SEL_IDX]<=clk_req[SEL_IDX] and sw_busy<=0 -> RUN.
- During SW_*:
  - Other clk_en bits still track clk_req.
  - sel_req changes are ignored until back in RUN, where any mismatch starts a new switch.
- Lock loss: lock_s=0 in RAMP, RUN, SW_GATE or SW_SETTLE causes, on the next edge:
  - clk_en=0, ready=0, sw_busy=0, lock_lost=1, state=WAIT_LOCK.
  - clk1_sel is held.
- lock_lost: cleared by lock_lost_clr; a set in the same cycle wins.
- Latency: clk_en[0] rises exactly LOCK_WAIT+4 edges after mmcm_locked rises (2 sync + 1 WAIT_LOCK + LOCK_WAIT FILTER + 1).
- Reset asserted mid-operation forces reset values immediately (asynchronous).

Test Plan (N_CLK=4, SEL_IDX=1, LOCK_WAIT=64, EN_GAP=8, SW_GATE_WAIT=SW_SETTLE=16):
- Power-up: clk_req=4'hF, mmcm_locked rises at edge 0 -> clk_en[0] at edge 68, clk_en[1..3] at edges 76/84/92, ready at edge 99, lock_lost=0.
- Lock glitch: mmcm_locked high 40 cycles, low 5, high again -> no clk_en until LOCK_WAIT+4 edges after the final rise; lock_lost=0.
- Switch: in RUN with clk1_sel=0, set sel_req=1 -> clk_en[1] falls next edge, clk1_sel=1 sixteen edges later, clk_en[1] re-rises sixteen edges after that; sw_busy high for 32 cycles; clk_en[0,2,3] stay 1.
- sel_req toggles back during SW_SETTLE -> first switch completes, one RUN cycle, then a second full 32-cycle switch back to clk1_sel=0.
- Lock loss mid-switch: drop mmcm_locked in SW_GATE -> 3 edges later clk_en=0, ready=0, sw_busy=0, lock_lost=1; lock_lost_clr pulse clears it; relock repeats the full ramp.
- Partial request: clk_req=4'b1010 -> only clk_en[1] at edge 76 and clk_en[3] at edge 92; ready still at edge 99; later clk_req=4'hF -> clk_en=4'hF one edge later.

Source files
------------

// File: rtl/crg_clk_seq.sv
// Gate-enable and clk1-source sequencer for the clock/reset generator.
// Waits for stable MMCM lock, ramps enables in staggered slots, and switches the muxed clock glitch-free.
module crg_clk_seq #(
  parameter int   N_CLK        = 4,
  parameter int   SEL_IDX      = 1,
  parameter logic SEL_INIT     = 1'b0,
  parameter int   LOCK_WAIT    = 64,
  parameter int   EN_GAP       = 8,
  parameter int   SW_GATE_WAIT = 16,
  parameter int   SW_SETTLE    = 16,
  parameter int   CNT_W        = 16
) (
  input  logic             clk_src,
  input  logic             rst_n_sys,
  input  logic             mmcm_locked,
  input  logic [N_CLK-1:0] clk_req,
  input  logic             sel_req,
  input  logic             lock_lost_clr,
  output logic [N_CLK-1:0] clk_en,
  output logic             clk1_sel,
  output logic             ready,
  output logic             sw_busy,
  output logic             lock_lost
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_FILTER,
    S_RAMP,
    S_RUN,
    S_SW_GATE,
    S_SW_SETTLE
  } state_e;

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_WAIT - 1);
  localparam logic [CNT_W-1:0] RAMP_LAST   = CNT_W'(N_CLK * EN_GAP - 1);
  localparam logic [CNT_W-1:0] GATE_LAST   = CNT_W'(SW_GATE_WAIT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SW_SETTLE - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_CLK-1:0]   clk_en_q, clk_en_d;
  logic               clk1_sel_q, clk1_sel_d;
  logic               ready_q, ready_d;
  logic               sw_busy_q, sw_busy_d;
  logic               lock_lost_q, lock_lost_d;
  logic               lock_s1_q, lock_s_q;
  logic               lost_set;

  always_ff @(posedge clk_src or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      lock_s1_q   <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= S_WAIT_LOCK;
      cnt_q       <= '0;
      clk_en_q    <= '0;
      clk1_sel_q  <= SEL_INIT;
      ready_q     <= 1'b0;
      sw_busy_q   <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      lock_s1_q   <= mmcm_locked;
      lock_s_q    <= lock_s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_en_q    <= clk_en_d;
      clk1_sel_q  <= clk1_sel_d;
      ready_q     <= ready_d;
      sw_busy_q   <= sw_busy_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_en_d   = clk_en_q;
    clk1_sel_d = clk1_sel_q;
    ready_d    = ready_q;
    sw_busy_d  = sw_busy_q;
    lost_set   = 1'b0;

    case (state_q)
      S_WAIT_LOCK: begin
        clk_en_d = '0;
        ready_d  = 1'b0;
        if (lock_s_q) begin
          state_d = S_FILTER;
          cnt_d   = '0;
        end
      end
      S_FILTER: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == LOCK_LAST) begin
          state_d    = S_RAMP;
          cnt_d      = '0;
          clk1_sel_d = sel_req;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RAMP: begin
        // Bits whose slot has come track their request; later slots stay off.
        for (int i = 0; i < N_CLK; i++) begin
          clk_en_d[i] = (cnt_q >= CNT_W'(i * EN_GAP)) ? clk_req[i] : 1'b0;
        end
        if (cnt_q == RAMP_LAST) begin
          state_d = S_RUN;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        clk_en_d = clk_req;
        if (sel_req != clk1_sel_q) begin
          state_d           = S_SW_GATE;
          cnt_d             = '0;
          clk_en_d[SEL_IDX] = 1'b0;
          sw_busy_d         = 1'b1;
        end
      end
      S_SW_GATE: begin
        clk_en_d          = clk_req;
        clk_en_d[SEL_IDX] = 1'b0;
        if (cnt_q == GATE_LAST) begin
          state_d    = S_SW_SETTLE;
          cnt_d      = '0;
          clk1_sel_d = sel_req;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SW_SETTLE: begin
        clk_en_d          = clk_req;
        clk_en_d[SEL_IDX] = 1'b0;
        if (cnt_q == SETTLE_LAST) begin
          state_d           = S_RUN;
          cnt_d             = '0;
          clk_en_d[SEL_IDX] = clk_req[SEL_IDX];
          sw_busy_d         = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_WAIT_LOCK;
    endcase

    // Lock loss once ramp-up has begun overrides everything except the mux select.
    if (!lock_s_q && (state_q == S_RAMP || state_q == S_RUN ||
                      state_q == S_SW_GATE || state_q == S_SW_SETTLE)) begin
      state_d   = S_WAIT_LOCK;
      cnt_d     = '0;
      clk_en_d  = '0;
      ready_d   = 1'b0;
      sw_busy_d = 1'b0;
      lost_set  = 1'b1;
    end

    lock_lost_d = lost_set | (lock_lost_q & ~lock_lost_clr);
  end

  assign clk_en    = clk_en_q;
  assign clk1_sel  = clk1_sel_q;
  assign ready     = ready_q;
  assign sw_busy   = sw_busy_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_crg_clk_seq.sv
// Bench for crg_clk_seq: power-up vector tables, directed switch/lock-loss sequences,
// and randomized traffic compared every cycle against an elapsed-time reference model.
module tb_crg_clk_seq;
  localparam int N_CLK = 4, SEL_IDX = 1, LOCK_WAIT = 64, EN_GAP = 8, GW = 16, SS = 16;

  logic             clk_src = 1'b0;
  logic             rst_n_sys = 1'b0;
  logic             mmcm_locked = 1'b0;
  logic [N_CLK-1:0] clk_req = '0;
  logic             sel_req = 1'b0;
  logic             lock_lost_clr = 1'b0;
  logic [N_CLK-1:0] clk_en;
  logic             clk1_sel, ready, sw_busy, lock_lost;

  crg_clk_seq #(
    .N_CLK(N_CLK), .SEL_IDX(SEL_IDX), .SEL_INIT(1'b0), .LOCK_WAIT(LOCK_WAIT),
    .EN_GAP(EN_GAP), .SW_GATE_WAIT(GW), .SW_SETTLE(SS), .CNT_W(16)
  ) dut (
    .clk_src(clk_src), .rst_n_sys(rst_n_sys), .mmcm_locked(mmcm_locked),
    .clk_req(clk_req), .sel_req(sel_req), .lock_lost_clr(lock_lost_clr),
    .clk_en(clk_en), .clk1_sel(clk1_sel), .ready(ready), .sw_busy(sw_busy),
    .lock_lost(lock_lost)
  );

  always #5 clk_src = ~clk_src;

  int n_tests = 0;
  int n_fail  = 0;
  int e       = 0;

  // Reference model: phases with elapsed-cycle counters.
  localparam int P_IDLE = 0, P_FILT = 1, P_RAMP = 2, P_RUN = 3, P_SW = 4;
  int               m_phase, m_k;
  logic             m_s1, m_s;
  logic [N_CLK-1:0] m_en;
  logic             m_sel, m_rdy, m_busy, m_lost;

  task automatic model_reset();
    m_phase = P_IDLE; m_k = 0; m_s1 = 1'b0; m_s = 1'b0;
    m_en = '0; m_sel = 1'b0; m_rdy = 1'b0; m_busy = 1'b0; m_lost = 1'b0;
  endtask

  task automatic model_step();
    logic ls, set;
    ls  = m_s;
    set = 1'b0;
    if (m_phase == P_IDLE) begin
      m_en = '0;
      if (ls) begin m_phase = P_FILT; m_k = 0; end
    end else if (m_phase == P_FILT) begin
      if (!ls) m_phase = P_IDLE;
      else begin
        m_k++;
        if (m_k == LOCK_WAIT) begin m_phase = P_RAMP; m_k = 0; m_sel = sel_req; end
      end
    end else if (!ls) begin
      m_en = '0; m_rdy = 1'b0; m_busy = 1'b0; set = 1'b1; m_phase = P_IDLE;
    end else if (m_phase == P_RAMP) begin
      for (int i = 0; i < N_CLK; i++) m_en[i] = (m_k >= i * EN_GAP) ? clk_req[i] : 1'b0;
      m_k++;
      if (m_k == N_CLK * EN_GAP) begin m_phase = P_RUN; m_rdy = 1'b1; end
    end else if (m_phase == P_RUN) begin
      m_en = clk_req;
      if (sel_req != m_sel) begin
        m_phase = P_SW; m_k = 0; m_en[SEL_IDX] = 1'b0; m_busy = 1'b1;
      end
    end else begin
      m_en = clk_req;
      m_en[SEL_IDX] = 1'b0;
      if (m_k == GW - 1) m_sel = sel_req;
      if (m_k == GW + SS - 1) begin
        m_en[SEL_IDX] = clk_req[SEL_IDX]; m_busy = 1'b0; m_phase = P_RUN;
      end
      m_k++;
    end
    m_lost = set ? 1'b1 : (lock_lost_clr ? 1'b0 : m_lost);
    m_s  = m_s1;
    m_s1 = mmcm_locked;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, e, $time);
    end
  endtask

  function automatic logic [7:0] dut_vec();
    return {clk_en, clk1_sel, ready, sw_busy, lock_lost};
  endfunction

  function automatic logic [7:0] mdl_vec();
    return {m_en, m_sel, m_rdy, m_busy, m_lost};
  endfunction

  task automatic step();
    @(posedge clk_src);
    if (rst_n_sys) model_step();
    @(negedge clk_src);
    e++;
    if (rst_n_sys) chk("model", dut_vec(), mdl_vec());
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    @(negedge clk_src);
    rst_n_sys = 1'b0; mmcm_locked = 1'b0; clk_req = 4'hF; sel_req = 1'b0; lock_lost_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_src);
    chk("reset_state", dut_vec(), 8'h00);
    rst_n_sys = 1'b1;
  endtask

  typedef struct {
    logic [N_CLK-1:0] req;
    int               edge_n;
    logic [N_CLK-1:0] en;
    logic             rdy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    logic [N_CLK-1:0] cur_req;
    tbl[0]  = '{4'hF, 67, 4'h0, 1'b0};
    tbl[1]  = '{4'hF, 68, 4'h1, 1'b0};
    tbl[2]  = '{4'hF, 75, 4'h1, 1'b0};
    tbl[3]  = '{4'hF, 76, 4'h3, 1'b0};
    tbl[4]  = '{4'hF, 84, 4'h7, 1'b0};
    tbl[5]  = '{4'hF, 91, 4'h7, 1'b0};
    tbl[6]  = '{4'hF, 92, 4'hF, 1'b0};
    tbl[7]  = '{4'hF, 98, 4'hF, 1'b0};
    tbl[8]  = '{4'hF, 99, 4'hF, 1'b1};
    tbl[9]  = '{4'hA, 68, 4'h0, 1'b0};
    tbl[10] = '{4'hA, 75, 4'h0, 1'b0};
    tbl[11] = '{4'hA, 76, 4'h2, 1'b0};
    tbl[12] = '{4'hA, 91, 4'h2, 1'b0};
    tbl[13] = '{4'hA, 92, 4'hA, 1'b0};
    tbl[14] = '{4'hA, 98, 4'hA, 1'b0};
    tbl[15] = '{4'hA, 99, 4'hA, 1'b1};

    cur_req = 'x;
    foreach (tbl[i]) begin
      if (tbl[i].req !== cur_req || tbl[i].edge_n < e) begin
        do_reset();
        clk_req = tbl[i].req; cur_req = tbl[i].req;
        mmcm_locked = 1'b1; e = 0;
      end
      while (e < tbl[i].edge_n) step();
      chk($sformatf("pwr_en_%0h_e%0d", tbl[i].req, tbl[i].edge_n), clk_en, tbl[i].en);
      chk($sformatf("pwr_rdy_%0h_e%0d", tbl[i].req, tbl[i].edge_n), ready, tbl[i].rdy);
    end
    chk("pwr_lock_lost", lock_lost, 1'b0);
    clk_req = 4'hF;
    step();
    chk("req_full", clk_en, 4'hF);

    // Lock glitch restarts the filter from scratch.
    do_reset();
    mmcm_locked = 1'b1; steps(40);
    mmcm_locked = 1'b0; steps(5);
    mmcm_locked = 1'b1; e = 0;
    steps(67);
    chk("glitch_en_early", clk_en, 4'h0);
    step();
    chk("glitch_en0", clk_en, 4'h1);
    chk("glitch_lost", lock_lost, 1'b0);
    steps(31);
    chk("glitch_ready", ready, 1'b1);

    // Source switch 0 -> 1.
    sel_req = 1'b1; step();
    chk("sw_gate_en", clk_en, 4'hD);
    chk("sw_gate_busy", sw_busy, 1'b1);
    steps(15);
    chk("sw_sel_hold", clk1_sel, 1'b0);
    step();
    chk("sw_sel_new", clk1_sel, 1'b1);
    chk("sw_settle_en", clk_en, 4'hD);
    steps(15);
    chk("sw_busy_late", sw_busy, 1'b1);
    step();
    chk("sw_done_en", clk_en, 4'hF);
    chk("sw_done_busy", sw_busy, 1'b0);

    // Request reverses during settle: finish, one RUN cycle, switch again.
    sel_req = 1'b0; step();
    steps(20);
    sel_req = 1'b1;
    steps(12);
    chk("tog_first_busy", sw_busy, 1'b0);
    chk("tog_first_sel", clk1_sel, 1'b0);
    chk("tog_first_en", clk_en, 4'hF);
    step();
    chk("tog_second_busy", sw_busy, 1'b1);
    chk("tog_second_en", clk_en, 4'hD);
    steps(16);
    chk("tog_second_sel", clk1_sel, 1'b1);
    steps(16);
    chk("tog_second_done", {clk_en, sw_busy}, {4'hF, 1'b0});

    // Lock loss mid-switch, clear, relock.
    sel_req = 1'b0; step();
    steps(5);
    mmcm_locked = 1'b0;
    steps(2);
    chk("loss_pending", {clk_en, sw_busy}, {4'hD, 1'b1});
    step();
    chk("loss_outputs", {clk_en, ready, sw_busy, lock_lost}, {4'h0, 1'b0, 1'b0, 1'b1});
    chk("loss_sel_held", clk1_sel, 1'b1);
    lock_lost_clr = 1'b1; step(); lock_lost_clr = 1'b0;
    chk("loss_clear", lock_lost, 1'b0);
    mmcm_locked = 1'b1; e = 0;
    steps(67);
    chk("relock_en_early", clk_en, 4'h0);
    chk("relock_sel", clk1_sel, 1'b0);
    step();
    chk("relock_en0", clk_en, 4'h1);
    steps(31);
    chk("relock_ready", {clk_en, ready}, {4'hF, 1'b1});

    // Asynchronous reset between clock edges.
    #2 rst_n_sys = 1'b0;
    #1 chk("async_reset", dut_vec(), 8'h00);
    model_reset();
    @(negedge clk_src);
    rst_n_sys = 1'b1;

    // Randomized traffic against the model.
    mmcm_locked = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if (mmcm_locked ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 15) == 0))
        mmcm_locked = ~mmcm_locked;
      if ($urandom_range(0, 19) == 0) clk_req = N_CLK'($urandom);
      if ($urandom_range(0, 59) == 0) sel_req = ~sel_req;
      lock_lost_clr = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
